// File: rtl/pe_idx_dispatcher_if.sv
// -----------------------------------------------------------------------------
// pe_idx_dispatcher_if
//   Bundles every handshake and data signal around the PE index dispatcher:
//   the descriptor channel from instruction fetch, the index-word stream, the
//   write port into the AGU's ping-pong index buffer and the AGU control and
//   instruction fields.
//
//   master : dispatcher view (accepts descriptors and index words, drives the
//            index buffer write port, the swap/start pulses and AGU fields).
//   slave  : surrounding view (fetch path, index buffer and AGU).
// -----------------------------------------------------------------------------
interface pe_idx_dispatcher_if #(
    parameter int IDX_W      = 4,
    parameter int IDX_ADDR_W = 8
);
    // Descriptor channel
    logic                  ins_valid;
    logic                  ins_ready;
    logic [2:0]            ins_mode;
    logic [7:0]            ins_idx_cnt;
    logic [7:0]            ins_trip_cnt;
    logic                  ins_is_new;
    logic [3:0]            ins_pad_code;
    logic                  ins_cut_y;

    // Index word stream
    logic [2*IDX_W-1:0]    idx_in_data;
    logic                  idx_in_valid;
    logic                  idx_in_ready;

    // Index buffer write port
    logic [2*IDX_W-1:0]    idx_wr_data;
    logic [IDX_ADDR_W-1:0] idx_wr_addr;
    logic                  idx_wr_en;

    // AGU control and instruction fields
    logic                  switch_idx_buf;
    logic                  agu_start;
    logic                  agu_done;
    logic [2:0]            agu_mode;
    logic [7:0]            agu_idx_cnt;
    logic [7:0]            agu_trip_cnt;
    logic                  agu_is_new;
    logic [3:0]            agu_pad_code;
    logic                  agu_cut_y;
    logic                  busy;

    modport master (
        input  ins_valid, ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new,
               ins_pad_code, ins_cut_y, idx_in_data, idx_in_valid, agu_done,
        output ins_ready, idx_in_ready, idx_wr_data, idx_wr_addr, idx_wr_en,
               switch_idx_buf, agu_start, agu_mode, agu_idx_cnt, agu_trip_cnt,
               agu_is_new, agu_pad_code, agu_cut_y, busy
    );

    modport slave (
        output ins_valid, ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new,
               ins_pad_code, ins_cut_y, idx_in_data, idx_in_valid, agu_done,
        input  ins_ready, idx_in_ready, idx_wr_data, idx_wr_addr, idx_wr_en,
               switch_idx_buf, agu_start, agu_mode, agu_idx_cnt, agu_trip_cnt,
               agu_is_new, agu_pad_code, agu_cut_y, busy
    );
endinterface

// File: rtl/pe_idx_dispatcher.sv
// -----------------------------------------------------------------------------
// pe_idx_dispatcher
//   Producer side of the PE address-generation unit. Accepts one instruction
//   descriptor at a time, streams its index words into the write half of the
//   AGU's ping-pong index buffer, waits for the AGU to finish the previous
//   instruction, swaps the buffer halves and issues the new instruction.
//   Loading the next descriptor overlaps with AGU execution of the current one.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - pe_idx_dispatcher_if.master:
//          ins_*          descriptor valid/ready handshake and fields
//          idx_in_*       index word valid/ready stream
//          idx_wr_*       registered index buffer write (1-cycle latency)
//          switch_idx_buf one-cycle ping-pong swap pulse
//          agu_start      one-cycle instruction start pulse
//          agu_done       AGU idle/done level
//          agu_*          instruction fields, held until the next start
//          busy           dispatcher not idle or AGU still running
// -----------------------------------------------------------------------------
module pe_idx_dispatcher #(
    parameter int IDX_W      = 4,
    parameter int IDX_DEPTH  = 256,
    parameter int IDX_ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    pe_idx_dispatcher_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_AGU = 3'd2,
        SWITCH   = 3'd3,
        ISSUE    = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic ins_ready_c;
    logic idx_ready_c;
    logic ins_hs;
    logic idx_hs;
    logic last_word;

    // Shadow copy of the accepted descriptor
    logic [2:0] sh_mode;
    logic [7:0] sh_idx_cnt;
    logic [7:0] sh_trip_cnt;
    logic       sh_is_new;
    logic [3:0] sh_pad_code;
    logic       sh_cut_y;

    logic [7:0]            word_cnt;
    logic [IDX_ADDR_W-1:0] wr_addr;

    logic                  vld_p1;
    logic [IDX_ADDR_W-1:0] wr_addr_p1;
    logic [2*IDX_W-1:0]    wr_data_p1;
    logic                  switch_p1;
    logic                  start_p1;
    logic [2:0]            agu_mode_p1;
    logic [7:0]            agu_idx_cnt_p1;
    logic [7:0]            agu_trip_cnt_p1;
    logic                  agu_is_new_p1;
    logic [3:0]            agu_pad_code_p1;
    logic                  agu_cut_y_p1;

    // Readiness is masked by rst so nothing is accepted while reset is held.
    assign ins_ready_c = (state == IDLE) & ~rst;
    assign idx_ready_c = (state == LOAD) & ~rst;
    assign ins_hs      = bus.ins_valid & ins_ready_c;
    assign idx_hs      = bus.idx_in_valid & idx_ready_c;
    assign last_word   = (word_cnt == (sh_idx_cnt - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ins_hs) begin
                    state_next = (bus.ins_idx_cnt != 8'd0) ? LOAD : WAIT_AGU;
                end
            end
            LOAD: begin
                if (idx_hs && last_word) begin
                    state_next = WAIT_AGU;
                end
            end
            WAIT_AGU: begin
                if (bus.agu_done) begin
                    state_next = SWITCH;
                end
            end
            SWITCH:  state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word counter and write address restart with every new descriptor; the
    // address wraps so an oversized count overwrites from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= 8'd0;
            wr_addr  <= '0;
        end else if (ins_hs) begin
            word_cnt <= 8'd0;
            wr_addr  <= '0;
        end else if (idx_hs) begin
            word_cnt <= word_cnt + 8'd1;
            if (wr_addr == IDX_ADDR_W'(IDX_DEPTH - 1)) begin
                wr_addr <= '0;
            end else begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ins_hs) begin
            sh_mode     <= bus.ins_mode;
            sh_idx_cnt  <= bus.ins_idx_cnt;
            sh_trip_cnt <= bus.ins_trip_cnt;
            sh_is_new   <= bus.ins_is_new;
            sh_pad_code <= bus.ins_pad_code;
            sh_cut_y    <= bus.ins_cut_y;
        end
    end

    // ---- stage p1: registered buffer write and AGU outputs ----
    // Pulses are keyed off state_next so each one lines up with the cycle the
    // FSM sits in SWITCH / ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1          <= 1'b0;
            wr_addr_p1      <= '0;
            wr_data_p1      <= '0;
            switch_p1       <= 1'b0;
            start_p1        <= 1'b0;
            agu_mode_p1     <= 3'd0;
            agu_idx_cnt_p1  <= 8'd0;
            agu_trip_cnt_p1 <= 8'd0;
            agu_is_new_p1   <= 1'b0;
            agu_pad_code_p1 <= 4'd0;
            agu_cut_y_p1    <= 1'b0;
        end else begin
            vld_p1 <= idx_hs;
            if (idx_hs) begin
                wr_addr_p1 <= wr_addr;
                wr_data_p1 <= bus.idx_in_data;
            end
            switch_p1 <= (state_next == SWITCH);
            start_p1  <= (state_next == ISSUE);
            if (state_next == ISSUE) begin
                agu_mode_p1     <= sh_mode;
                agu_idx_cnt_p1  <= sh_idx_cnt;
                agu_trip_cnt_p1 <= sh_trip_cnt;
                agu_is_new_p1   <= sh_is_new;
                agu_pad_code_p1 <= sh_pad_code;
                agu_cut_y_p1    <= sh_cut_y;
            end
        end
    end

    assign bus.ins_ready      = ins_ready_c;
    assign bus.idx_in_ready   = idx_ready_c;
    assign bus.idx_wr_en      = vld_p1;
    assign bus.idx_wr_addr    = wr_addr_p1;
    assign bus.idx_wr_data    = wr_data_p1;
    assign bus.switch_idx_buf = switch_p1;
    assign bus.agu_start      = start_p1;
    assign bus.agu_mode       = agu_mode_p1;
    assign bus.agu_idx_cnt    = agu_idx_cnt_p1;
    assign bus.agu_trip_cnt   = agu_trip_cnt_p1;
    assign bus.agu_is_new     = agu_is_new_p1;
    assign bus.agu_pad_code   = agu_pad_code_p1;
    assign bus.agu_cut_y      = agu_cut_y_p1;
    assign bus.busy           = (state != IDLE) | ~bus.agu_done;

endmodule

// File: tb/tb_pe_idx_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_pe_idx_dispatcher
//   Scoreboard bench: expected buffer writes and expected AGU instructions are
//   queued when the bench hands words / descriptors to the dispatcher and are
//   popped by a negedge monitor when the dispatcher produces them.
// -----------------------------------------------------------------------------
module tb_pe_idx_dispatcher;
    localparam int IDX_W      = 4;
    localparam int IDX_DEPTH  = 256;
    localparam int IDX_ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_idx_dispatcher_if #(.IDX_W(IDX_W), .IDX_ADDR_W(IDX_ADDR_W)) bus ();

    pe_idx_dispatcher #(
        .IDX_W(IDX_W), .IDX_DEPTH(IDX_DEPTH), .IDX_ADDR_W(IDX_ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] cnt;
        logic [7:0] trip;
        logic       is_new;
        logic [3:0] pad;
        logic       cut;
    } desc_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    desc_t      desc_q[$];
    wr_t        wr_q[$];
    logic [7:0] wq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sw_cnt = 0, st_cnt = 0, wr_cnt = 0;
    int last_sw_cyc = -1, last_st_cyc = -1;
    int exp_addr = 0;
    bit prev_sw = 1'b0;
    bit skip_stab = 1'b1;
    logic [24:0] l_fields = '0;
    logic [24:0] cur_fields;
    wr_t   mon_w;
    desc_t mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        cur_fields = {bus.agu_mode, bus.agu_idx_cnt, bus.agu_trip_cnt,
                      bus.agu_is_new, bus.agu_pad_code, bus.agu_cut_y};
        if (bus.idx_wr_en === 1'b1) begin
            wr_cnt++;
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got addr=%0d data=%h, none queued", bus.idx_wr_addr, bus.idx_wr_data);
            end else begin
                mon_w = wr_q.pop_front();
                if ({bus.idx_wr_addr, bus.idx_wr_data} !== mon_w) begin
                    bad++;
                    $display("FAIL wr_data got addr=%0d data=%h exp addr=%0d data=%h",
                             bus.idx_wr_addr, bus.idx_wr_data, mon_w.addr, mon_w.data);
                end
            end
        end
        if (bus.switch_idx_buf === 1'b1) begin
            sw_cnt++;
            last_sw_cyc = cyc;
        end
        if (bus.agu_start === 1'b1) begin
            st_cnt++;
            last_st_cyc = cyc;
            total++;
            if (!prev_sw) begin
                bad++;
                $display("FAIL start_after_switch got prev_switch=0 exp=1");
            end
            total++;
            if (desc_q.size() == 0) begin
                bad++;
                $display("FAIL start_unexpected got fields=%h, none queued", cur_fields);
            end else begin
                mon_d = desc_q.pop_front();
                if (cur_fields !== mon_d) begin
                    bad++;
                    $display("FAIL agu_fields got=%h exp=%h", cur_fields, mon_d);
                end
            end
        end else if (!skip_stab) begin
            total++;
            if (cur_fields !== l_fields) begin
                bad++;
                $display("FAIL agu_stable got=%h exp=%h", cur_fields, l_fields);
            end
        end
        l_fields = cur_fields;
        prev_sw  = (bus.switch_idx_buf === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_desc(input logic [7:0] cnt, input logic [2:0] mode,
                             input logic [7:0] trip, input logic is_new,
                             input logic [3:0] pad, input logic cut,
                             output int acc_cyc, output bit ok);
        int n;
        desc_t d;
        n = 0;
        @(negedge clk);
        bus.ins_idx_cnt  = cnt;
        bus.ins_mode     = mode;
        bus.ins_trip_cnt = trip;
        bus.ins_is_new   = is_new;
        bus.ins_pad_code = pad;
        bus.ins_cut_y    = cut;
        bus.ins_valid    = 1'b1;
        while (bus.ins_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.ins_ready === 1'b1);
        acc_cyc = cyc;
        if (ok) begin
            d = '{mode: mode, cnt: cnt, trip: trip, is_new: is_new, pad: pad, cut: cut};
            desc_q.push_back(d);
            exp_addr = 0;
            @(posedge clk);
            #1;
        end
        bus.ins_valid = 1'b0;
    endtask

    task automatic pump(input int n, input int budget, input bit hold,
                        input bit gaps, output int acc);
        int c;
        wr_t w;
        acc = 0;
        c = 0;
        while (acc < n && c < budget && wq.size() > 0) begin
            @(negedge clk);
            c++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.idx_in_valid = 1'b0;
            end else begin
                bus.idx_in_valid = 1'b1;
                bus.idx_in_data  = wq[0];
            end
            if (bus.idx_in_valid && bus.idx_in_ready === 1'b1) begin
                w.addr = 8'(exp_addr);
                w.data = wq.pop_front();
                wr_q.push_back(w);
                exp_addr = (exp_addr + 1) % IDX_DEPTH;
                acc++;
            end
        end
        @(posedge clk);
        #1;
        if (hold && wq.size() > 0) bus.idx_in_data = wq[0];
        else bus.idx_in_valid = 1'b0;
    endtask

    task automatic wait_start(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (st_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ok = (st_cnt >= target);
    endtask

    task automatic test_reset();
        bus.ins_valid = 0; bus.ins_mode = 0; bus.ins_idx_cnt = 0; bus.ins_trip_cnt = 0;
        bus.ins_is_new = 0; bus.ins_pad_code = 0; bus.ins_cut_y = 0;
        bus.idx_in_valid = 0; bus.idx_in_data = 0; bus.agu_done = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.ins_ready, bus.idx_in_ready, bus.idx_wr_en, bus.switch_idx_buf, bus.agu_start, bus.busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000000", {bus.ins_ready, bus.idx_in_ready, bus.idx_wr_en, bus.switch_idx_buf, bus.agu_start, bus.busy});
        end
        total++;
        if ({bus.idx_wr_addr, bus.idx_wr_data, bus.agu_mode, bus.agu_idx_cnt, bus.agu_trip_cnt,
             bus.agu_is_new, bus.agu_pad_code, bus.agu_cut_y} !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%h data=%h mode=%h cnt=%h exp all 0", bus.idx_wr_addr, bus.idx_wr_data, bus.agu_mode, bus.agu_idx_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.ins_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.ins_ready);
        end
        @(negedge clk);
        skip_stab = 1'b0;
    endtask

    task automatic test_basic();
        int b_sw, b_st, b_wr, acc, ac;
        bit ok;
        b_sw = sw_cnt; b_st = st_cnt; b_wr = wr_cnt;
        send_desc(8'd3, 3'b001, 8'd7, 1'b1, 4'b0101, 1'b0, ac, ok);
        wq = '{8'hA1, 8'hB2, 8'hC3};
        pump(3, 20, 1'b0, 1'b0, acc);
        wait_start(b_st + 1, 30, ok);
        total++;
        if (!ok || acc != 3) begin
            bad++;
            $display("FAIL basic_progress got acc=%0d started=%0d exp acc=3 started=1", acc, ok);
        end
        total++;
        if (wr_cnt - b_wr != 3 || sw_cnt - b_sw != 1 || st_cnt - b_st != 1) begin
            bad++;
            $display("FAIL basic_counts got wr=%0d sw=%0d st=%0d exp 3 1 1", wr_cnt - b_wr, sw_cnt - b_sw, st_cnt - b_st);
        end
        total++;
        if (last_st_cyc != last_sw_cyc + 1) begin
            bad++;
            $display("FAIL basic_sw_to_start got sw=%0d st=%0d exp st=sw+1", last_sw_cyc, last_st_cyc);
        end
        total++;
        if (bus.agu_mode !== 3'b001 || bus.agu_idx_cnt !== 8'd3) begin
            bad++;
            $display("FAIL basic_fields got mode=%b cnt=%0d exp mode=001 cnt=3", bus.agu_mode, bus.agu_idx_cnt);
        end
    endtask

    task automatic test_zero_cnt();
        int b_sw, b_st, b_wr, ac;
        bit ok, ok2;
        b_sw = sw_cnt; b_st = st_cnt; b_wr = wr_cnt;
        send_desc(8'd0, 3'b110, 8'd9, 1'b0, 4'b1000, 1'b1, ac, ok);
        wait_start(b_st + 1, 20, ok2);
        total++;
        if (!ok || !ok2 || wr_cnt != b_wr || sw_cnt - b_sw != 1) begin
            bad++;
            $display("FAIL zero_cnt got acc=%0d start=%0d wr=%0d sw=%0d exp 1 1 0 1", ok, ok2, wr_cnt - b_wr, sw_cnt - b_sw);
        end
        total++;
        if (last_st_cyc - ac > 3 || last_st_cyc - ac < 1) begin
            bad++;
            $display("FAIL zero_cnt_latency got=%0d exp<=3", last_st_cyc - ac);
        end
    endtask

    task automatic test_overlap();
        int b_sw, b_st, acc1, acc2, ac, drop_cyc, rise_cyc;
        bit ok, ok2;
        b_sw = sw_cnt; b_st = st_cnt;
        send_desc(8'd4, 3'b010, 8'd20, 1'b1, 4'b0011, 1'b0, ac, ok);
        wq = '{8'h01, 8'h23, 8'h45, 8'h67};
        pump(4, 20, 1'b0, 1'b0, acc1);
        wait_start(b_st + 1, 30, ok);
        bus.agu_done = 1'b0;
        drop_cyc = cyc;
        send_desc(8'd2, 3'b101, 8'd33, 1'b0, 4'b1100, 1'b1, ac, ok2);
        wq = '{8'h89, 8'hAB};
        pump(2, 20, 1'b0, 1'b0, acc2);
        total++;
        if (!ok || !ok2 || acc1 != 4 || acc2 != 2) begin
            bad++;
            $display("FAIL overlap_load got start1=%0d acc2=%0d w1=%0d w2=%0d exp 1 1 4 2", ok, ok2, acc1, acc2);
        end
        while (cyc < drop_cyc + 50) @(negedge clk);
        total++;
        if (sw_cnt != b_sw + 1 || st_cnt != b_st + 1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL overlap_hold got sw=%0d st=%0d busy=%b exp 1 1 1", sw_cnt - b_sw, st_cnt - b_st, bus.busy);
        end
        total++;
        if (bus.agu_mode !== 3'b010 || bus.agu_idx_cnt !== 8'd4) begin
            bad++;
            $display("FAIL overlap_fields_held got mode=%b cnt=%0d exp mode=010 cnt=4", bus.agu_mode, bus.agu_idx_cnt);
        end
        bus.agu_done = 1'b1;
        rise_cyc = cyc;
        wait_start(b_st + 2, 20, ok);
        total++;
        if (!ok || sw_cnt != b_sw + 2 || last_sw_cyc <= rise_cyc) begin
            bad++;
            $display("FAIL overlap_second got start=%0d sw=%0d sw_cyc=%0d rise=%0d exp sw after rise", ok, sw_cnt - b_sw, last_sw_cyc, rise_cyc);
        end
        total++;
        if (bus.agu_mode !== 3'b101 || bus.agu_idx_cnt !== 8'd2) begin
            bad++;
            $display("FAIL overlap_fields2 got mode=%b cnt=%0d exp mode=101 cnt=2", bus.agu_mode, bus.agu_idx_cnt);
        end
    endtask

    task automatic test_backpressure();
        int b_st, b_wr, acc, ac;
        bit ok, ok2;
        b_st = st_cnt; b_wr = wr_cnt;
        send_desc(8'd2, 3'b011, 8'd5, 1'b1, 4'b0000, 1'b0, ac, ok);
        wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pump(5, 12, 1'b1, 1'b0, acc);
        total++;
        if (acc != 2 || bus.idx_in_ready !== 1'b0 || wq.size() != 3) begin
            bad++;
            $display("FAIL bp_accept got acc=%0d ready=%b pending=%0d exp 2 0 3", acc, bus.idx_in_ready, wq.size());
        end
        wait_start(b_st + 1, 20, ok);
        send_desc(8'd3, 3'b100, 8'd6, 1'b0, 4'b0001, 1'b1, ac, ok2);
        pump(3, 20, 1'b0, 1'b0, acc);
        wait_start(b_st + 2, 20, ok2);
        total++;
        if (!ok || !ok2 || acc != 3 || wr_cnt - b_wr != 5) begin
            bad++;
            $display("FAIL bp_pending got start=%0d/%0d acc=%0d wr=%0d exp 1 1 3 5", ok, ok2, acc, wr_cnt - b_wr);
        end
    endtask

    task automatic test_reset_mid();
        int b_sw, b_st, b_wr, acc, ac;
        bit ok;
        b_sw = sw_cnt; b_st = st_cnt; b_wr = wr_cnt;
        skip_stab = 1'b1;
        send_desc(8'd4, 3'b111, 8'd44, 1'b1, 4'b1111, 1'b1, ac, ok);
        wq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        pump(1, 10, 1'b0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        desc_q.delete();
        wq.delete();
        @(negedge clk);
        total++;
        if ({bus.ins_ready, bus.idx_in_ready, bus.idx_wr_en, bus.switch_idx_buf, bus.agu_start} !== 5'b0) begin
            bad++;
            $display("FAIL rstmid_ctrl got=%b exp=00000", {bus.ins_ready, bus.idx_in_ready, bus.idx_wr_en, bus.switch_idx_buf, bus.agu_start});
        end
        total++;
        if ({bus.idx_wr_addr, bus.idx_wr_data, bus.agu_mode, bus.agu_idx_cnt, bus.agu_trip_cnt,
             bus.agu_is_new, bus.agu_pad_code, bus.agu_cut_y} !== '0) begin
            bad++;
            $display("FAIL rstmid_data got addr=%h data=%h mode=%h cnt=%h exp all 0", bus.idx_wr_addr, bus.idx_wr_data, bus.agu_mode, bus.agu_idx_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.ins_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready got=%b exp=1", bus.ins_ready);
        end
        repeat (10) @(negedge clk);
        total++;
        if (!ok || acc != 1 || sw_cnt != b_sw || st_cnt != b_st || wr_cnt - b_wr != 1) begin
            bad++;
            $display("FAIL rstmid_abort got acc=%0d sw=%0d st=%0d wr=%0d exp 1 0 0 1", acc, sw_cnt - b_sw, st_cnt - b_st, wr_cnt - b_wr);
        end
        skip_stab = 1'b0;
    endtask

    task automatic test_long();
        int b_sw, b_st, b_wr, acc, ac;
        bit ok, ok2;
        b_sw = sw_cnt; b_st = st_cnt; b_wr = wr_cnt;
        send_desc(8'd255, 3'b001, 8'd255, 1'b0, 4'b0110, 1'b0, ac, ok);
        for (int i = 0; i < 255; i++) wq.push_back(8'($urandom));
        pump(255, 3000, 1'b0, 1'b1, acc);
        wait_start(b_st + 1, 30, ok2);
        total++;
        if (!ok || !ok2 || acc != 255 || wr_cnt - b_wr != 255) begin
            bad++;
            $display("FAIL long_writes got acc=%0d wr=%0d start=%0d exp 255 255 1", acc, wr_cnt - b_wr, ok2);
        end
        total++;
        if (sw_cnt - b_sw != 1 || st_cnt - b_st != 1) begin
            bad++;
            $display("FAIL long_single got sw=%0d st=%0d exp 1 1", sw_cnt - b_sw, st_cnt - b_st);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cnt();
        test_overlap();
        test_backpressure();
        test_reset_mid();
        test_long();
        repeat (3) @(negedge clk);
        total++;
        if (wr_q.size() != 0 || desc_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got writes=%0d descs=%0d exp 0 0", wr_q.size(), desc_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_idx_dispatcher.md
Name: pe_idx_dispatcher

Overview:
- Producer side of the PE address-generation unit. Streams index pairs into the AGU's ping-pong index buffer, swaps buffer halves, and issues one AGU instruction per descriptor.
- Sits between the PE-group instruction/index fetch path and the AGU.
- Loads the next descriptor's indices into the write half while the AGU executes from the read half.

Parameters:
- IDX_W, 4, width of one index; one buffer word is two indices.
- IDX_DEPTH, 256, depth of each index buffer half.
- IDX_ADDR_W, 8, index buffer address width (log2 of IDX_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- ins_valid  in  1  instruction descriptor valid.
- ins_ready  out  1  descriptor accepted on a cycle where ins_valid and ins_ready are both high.
- ins_mode  in  3  {phase[1:0], layer}.
- ins_idx_cnt  in  8  number of index words for this descriptor.
- ins_trip_cnt  in  8  AGU trip count.
- ins_is_new  in  1  new-accumulation flag.
- ins_pad_code  in  4  {R,L,D,U} padding.
- ins_cut_y  in  1  row cut flag.
- idx_in_data  in  2*IDX_W  index word.
- idx_in_valid  in  1  index word valid.
- idx_in_ready  out  1  index word accepted on a cycle where idx_in_valid and idx_in_ready are both high.
- idx_wr_data  out  2*IDX_W  buffer write data.
- idx_wr_addr  out  IDX_ADDR_W  buffer write address.
- idx_wr_en  out  1  buffer write enable.
- switch_idx_buf  out  1  one-cycle ping-pong swap pulse.
- agu_start  out  1  one-cycle instruction start pulse.
- agu_done  in  1  AGU idle/done level.
- agu_mode, agu_idx_cnt, agu_trip_cnt, agu_is_new, agu_pad_code, agu_cut_y  out  3/8/8/1/4/1  instruction fields to the AGU.
- busy  out  1  dispatcher or AGU active.

Behaviour:
- States: IDLE, LOAD, WAIT_AGU, SWITCH, ISSUE.
- Reset: state=IDLE. All registered outputs are 0, including agu_* fields, idx_wr_*, switch_idx_buf and agu_start. The word counter and write address are 0.
  - ins_ready = (state==IDLE) & ~rst, so it is 0 during reset.
  - Reset mid-operation aborts everything: any partial load is discarded and no switch or start is emitted.
- IDLE: on descriptor handshake, latch all ins_* fields into a shadow register and clear the write address and word counter.
  - Next state is LOAD if ins_idx_cnt != 0, else WAIT_AGU.
- LOAD: idx_in_ready = 1. Each accepted word is registered into idx_wr_data/idx_wr_addr with idx_wr_en=1, giving 1-cycle write latency.
  - The write address increments per word and wraps modulo IDX_DEPTH. ins_idx_cnt must not exceed IDX_DEPTH; a larger value overwrites from address 0.
  - On the handshake of word idx_cnt-1, go to WAIT_AGU.
  - idx_in_ready = 0 in every other state; surplus words are back-pressured, never dropped.
- WAIT_AGU: hold until agu_done==1, then go to SWITCH.
  - This state is never entered in the cycle immediately after ISSUE, because IDLE intervenes. The AGU's registered done therefore always reflects the previous start.
- SWITCH: switch_idx_buf=1 for exactly one cycle; this follows the last idx_wr_en by at least 1 cycle. Next state is ISSUE.
- ISSUE:
  - agu_start=1 for exactly one cycle.
  - agu_* fields are driven from the shadow register in the same cycle.
  - agu_* fields stay stable until the next ISSUE.
  - Next state is IDLE.
- Overlap: after ISSUE the next descriptor may be accepted and loaded while the AGU runs. The second SWITCH waits for agu_done.
- busy = (state!=IDLE) | ~agu_done.
- Simultaneous ins_valid and idx_in_valid in IDLE: only the descriptor is accepted; index words wait for LOAD.

Test Plan:
- Reset, then agu_done=1; send descriptor idx_cnt=3, mode=3'b001 with words A,B,C back-to-back → idx_wr_en at addr 0,1,2 carrying A,B,C; one switch pulse; the next cycle one agu_start with agu_mode=001 and agu_idx_cnt=3.
- Descriptor idx_cnt=0 with agu_done=1 → no idx_wr_en; switch then start within 3 cycles of acceptance.
- Two descriptors (cnt 4, then 2) with agu_done dropping after the first start and rising 50 cycles later → second load completes during AGU busy; second switch occurs only after agu_done rises; agu_* fields stay unchanged until the second start.
- idx_in_valid held high with 5 words for idx_cnt=2 → exactly 2 words accepted; idx_in_ready=0 afterwards; words 3-5 remain pending for the next descriptor.
- Assert rst during LOAD after 1 of 4 words → all outputs 0 the next cycle; no switch or start; ins_ready=1 once rst falls.
- idx_cnt=255 with random idx_in_valid gaps → addresses 0..254 each written once in order; single switch and start.
